// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: wrap/saturate policy applied
// when a step crosses the programmed bounds.
package counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

endpackage : counter_pkg

// File: rtl/updown_next.sv
// Combinational next-state for the bounded up/down counter: applies one step
// and decides wrap/saturate plus the overflow/underflow flags.
module updown_next
  import counter_pkg::*;
#(
  parameter int    WIDTH      = 32,
  parameter int    STEP_WIDTH = 8,
  parameter mode_e MODE       = MODE_WRAP
) (
  input  logic [WIDTH-1:0]      i_count,
  input  logic [STEP_WIDTH-1:0] i_step,
  input  logic                  i_down,
  input  logic [WIDTH-1:0]      i_lim_lo,
  input  logic [WIDTH-1:0]      i_lim_hi,
  output logic [WIDTH-1:0]      o_next_count,
  output logic                  o_ovf_next,
  output logic                  o_unf_next
);

  logic        [WIDTH:0] w_step_ext;
  logic        [WIDTH:0] w_sum;
  logic signed [WIDTH:0] w_diff;

  // Landing point after a crossing; the remainder is deliberately dropped.
  function automatic logic [WIDTH-1:0] f_cross_target(
    input logic             up,
    input logic [WIDTH-1:0] lo,
    input logic [WIDTH-1:0] hi
  );
    if (MODE == MODE_SAT) return up ? hi : lo;
    else                  return up ? lo : hi;
  endfunction

  assign w_step_ext = {{(WIDTH+1-STEP_WIDTH){1'b0}}, i_step};
  assign w_sum      = {1'b0, i_count} + w_step_ext;
  assign w_diff     = $signed({1'b0, i_count}) - $signed(w_step_ext);

  always_comb begin
    o_next_count = i_count;
    o_ovf_next   = 1'b0;
    o_unf_next   = 1'b0;
    // A zero step is a pure hold, even when the count sits outside the range.
    if (i_step != '0) begin
      if (!i_down) begin
        if (w_sum > {1'b0, i_lim_hi}) begin
          o_next_count = f_cross_target(1'b1, i_lim_lo, i_lim_hi);
          o_ovf_next   = 1'b1;
        end else begin
          o_next_count = w_sum[WIDTH-1:0];
        end
      end else begin
        if (w_diff < $signed({1'b0, i_lim_lo})) begin
          o_next_count = f_cross_target(1'b0, i_lim_lo, i_lim_hi);
          o_unf_next   = 1'b1;
        end else begin
          o_next_count = w_diff[WIDTH-1:0];
        end
      end
    end
  end

endmodule : updown_next

// File: rtl/updown_counter_bounded.sv
// Bounded up/down counter with programmable limits, variable step, load and
// wrap/saturate policy; reports bound hits and crossing pulses.
module updown_counter_bounded
  import counter_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               STEP_WIDTH  = 8,
  parameter mode_e            MODE        = MODE_WRAP,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  down,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [WIDTH-1:0]      lim_lo,
  input  logic [WIDTH-1:0]      lim_hi,
  output logic [WIDTH-1:0]      count,
  output logic                  at_lo,
  output logic                  at_hi,
  output logic                  ovf,
  output logic                  unf
);

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;
  logic [WIDTH-1:0] w_next_count;
  logic             w_ovf_next;
  logic             w_unf_next;

  updown_next #(
    .WIDTH      (WIDTH),
    .STEP_WIDTH (STEP_WIDTH),
    .MODE       (MODE)
  ) u_next (
    .i_count      (r_count),
    .i_step       (step),
    .i_down       (down),
    .i_lim_lo     (lim_lo),
    .i_lim_hi     (lim_hi),
    .o_next_count (w_next_count),
    .o_ovf_next   (w_ovf_next),
    .o_unf_next   (w_unf_next)
  );

  // Stage p0 -> output register: priority rst > load > en > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= RESET_VALUE;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (load) begin
      r_count <= load_value;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (en) begin
      r_count <= w_next_count;
      r_ovf   <= w_ovf_next;
      r_unf   <= w_unf_next;
    end else begin
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end
  end

  assign count = r_count;
  assign ovf   = r_ovf;
  assign unf   = r_unf;
  assign at_lo = (r_count == lim_lo);
  assign at_hi = (r_count == lim_hi);

endmodule : updown_counter_bounded

// File: tb/tb_updown_counter_bounded.sv
// Scoreboard bench: one WRAP and one SAT instance share stimulus; expected
// outputs per cycle are queued by the driver and checked by a monitor.
module tb_updown_counter_bounded;
  import counter_pkg::*;

  typedef struct packed {
    logic [7:0] cnt;
    logic       alo;
    logic       ahi;
    logic       ovf;
    logic       unf;
  } exp_t;

  typedef struct {
    int   id;
    exp_t w;
    exp_t s;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, down = 1'b0, load = 1'b0;
  logic [7:0] step = '0, load_value = '0, lim_lo = '0, lim_hi = 8'd255;

  logic [7:0] count_w, count_s;
  logic       at_lo_w, at_hi_w, ovf_w, unf_w;
  logic       at_lo_s, at_hi_s, ovf_s, unf_s;

  entry_t sb[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     step_id  = 0;

  always #5 clk = ~clk;

  updown_counter_bounded #(
    .WIDTH(8), .STEP_WIDTH(8), .MODE(MODE_WRAP), .RESET_VALUE(8'd5)
  ) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .down(down), .step(step), .load(load),
    .load_value(load_value), .lim_lo(lim_lo), .lim_hi(lim_hi),
    .count(count_w), .at_lo(at_lo_w), .at_hi(at_hi_w), .ovf(ovf_w), .unf(unf_w)
  );

  updown_counter_bounded #(
    .WIDTH(8), .STEP_WIDTH(8), .MODE(MODE_SAT), .RESET_VALUE(8'd5)
  ) dut_sat (
    .clk(clk), .rst(rst), .en(en), .down(down), .step(step), .load(load),
    .load_value(load_value), .lim_lo(lim_lo), .lim_hi(lim_hi),
    .count(count_s), .at_lo(at_lo_s), .at_hi(at_hi_s), .ovf(ovf_s), .unf(unf_s)
  );

  function automatic exp_t mk(input int c, input bit alo, input bit ahi,
                              input bit o, input bit u);
    exp_t e;
    e.cnt = c[7:0];
    e.alo = alo;
    e.ahi = ahi;
    e.ovf = o;
    e.unf = u;
    return e;
  endfunction

  task automatic check(input int id, input string tag, input exp_t act, input exp_t req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL step%0d %s actual cnt=%0d at_lo=%b at_hi=%b ovf=%b unf=%b required cnt=%0d at_lo=%b at_hi=%b ovf=%b unf=%b",
               id, tag, act.cnt, act.alo, act.ahi, act.ovf, act.unf,
               req.cnt, req.alo, req.ahi, req.ovf, req.unf);
    end
  endtask

  // Monitor: the registered result of each driven cycle is visible 1 time unit
  // after the capturing edge.
  always @(posedge clk) begin
    entry_t e;
    exp_t   aw, as_;
    #1;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      aw  = {count_w, at_lo_w, at_hi_w, ovf_w, unf_w};
      as_ = {count_s, at_lo_s, at_hi_s, ovf_s, unf_s};
      check(e.id, "wrap", aw, e.w);
      check(e.id, "sat",  as_, e.s);
    end
  end

  task automatic drive(input bit r, input bit e, input bit d, input int st,
                       input bit ld, input int lv, input int lo, input int hi,
                       input exp_t ew, input exp_t es);
    entry_t ent;
    @(negedge clk);
    rst        = r;
    en         = e;
    down       = d;
    step       = st[7:0];
    load       = ld;
    load_value = lv[7:0];
    lim_lo     = lo[7:0];
    lim_hi     = hi[7:0];
    step_id++;
    ent.id = step_id;
    ent.w  = ew;
    ent.s  = es;
    sb.push_back(ent);
  endtask

  initial begin
    int wait_cycles;
    //    rst en dn st ld  lv  lo  hi   wrap expectation       sat expectation
    // Reset held two cycles with en high
    drive(1, 1, 0, 1, 0,  0,  0, 255, mk(5,0,0,0,0),   mk(5,0,0,0,0));
    drive(1, 1, 0, 1, 0,  0,  0, 255, mk(5,0,0,0,0),   mk(5,0,0,0,0));
    // Up across lim_hi = 20
    drive(0, 0, 0, 2, 1, 18, 10,  20, mk(18,0,0,0,0),  mk(18,0,0,0,0));
    drive(0, 1, 0, 2, 0,  0, 10,  20, mk(20,0,1,0,0),  mk(20,0,1,0,0));
    drive(0, 1, 0, 2, 0,  0, 10,  20, mk(10,1,0,1,0),  mk(20,0,1,1,0));
    drive(0, 1, 0, 2, 0,  0, 10,  20, mk(12,0,0,0,0),  mk(20,0,1,1,0));
    // Down across lim_lo = 10
    drive(0, 0, 0, 4, 1, 13, 10,  20, mk(13,0,0,0,0),  mk(13,0,0,0,0));
    drive(0, 1, 1, 4, 0,  0, 10,  20, mk(20,0,1,0,1),  mk(10,1,0,0,1));
    drive(0, 1, 1, 4, 0,  0, 10,  20, mk(16,0,0,0,0),  mk(10,1,0,0,1));
    // Carry bit: 250 + 10 = 260 on full range
    drive(0, 0, 0, 10, 1, 250, 0, 255, mk(250,0,0,0,0), mk(250,0,0,0,0));
    drive(0, 1, 0, 10, 0,  0,  0, 255, mk(0,1,0,1,0),   mk(255,0,1,1,0));
    // Load beats en; out-of-range count stepping away from the range
    drive(0, 0, 0, 1, 1, 15, 10,  20, mk(15,0,0,0,0),  mk(15,0,0,0,0));
    drive(0, 1, 0, 1, 1, 30, 10,  20, mk(30,0,0,0,0),  mk(30,0,0,0,0));
    drive(0, 1, 0, 1, 0,  0, 10,  20, mk(10,1,0,1,0),  mk(20,0,1,1,0));
    // Out-of-range count stepping toward the range: plain arithmetic
    drive(0, 0, 0, 1, 1, 30, 10,  20, mk(30,0,0,0,0),  mk(30,0,0,0,0));
    drive(0, 1, 1, 1, 0,  0, 10,  20, mk(29,0,0,0,0),  mk(29,0,0,0,0));
    // Mid-run reset overrides load and en
    drive(0, 0, 0, 2, 1, 15, 10,  20, mk(15,0,0,0,0),  mk(15,0,0,0,0));
    drive(0, 1, 0, 2, 0,  0, 10,  20, mk(17,0,0,0,0),  mk(17,0,0,0,0));
    drive(1, 1, 0, 2, 1, 99, 10,  20, mk(5,0,0,0,0),   mk(5,0,0,0,0));
    // Zero step holds, even below lim_lo
    drive(0, 1, 0, 0, 0,  0, 10,  20, mk(5,0,0,0,0),   mk(5,0,0,0,0));
    drive(0, 1, 1, 0, 0,  0, 10,  20, mk(5,0,0,0,0),   mk(5,0,0,0,0));
    drive(0, 1, 0, 0, 0,  0, 10,  20, mk(5,0,0,0,0),   mk(5,0,0,0,0));
    // Limit change shows up on at_lo immediately
    drive(0, 0, 0, 1, 0,  0,  5,  20, mk(5,1,0,0,0),   mk(5,1,0,0,0));
    drive(0, 1, 1, 1, 0,  0,  5,  20, mk(20,0,1,0,1),  mk(5,1,0,0,1));
    drive(0, 0, 0, 1, 0,  0,  5,  20, mk(20,0,1,0,0),  mk(5,1,0,0,0));

    @(negedge clk);
    en   = 1'b0;
    load = 1'b0;
    rst  = 1'b0;
    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain actual pending=%0d required pending=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_updown_counter_bounded

// File: doc/updown_counter_bounded.md
# updown_counter_bounded

Parametrised up/down counter with runtime-programmable lower/upper bounds, variable step, synchronous load and per-instance wrap or saturate mode. Generalises the free-running 32-bit up/down counter used in earlier experiments. Event counters, address sweeps and PWM/timebase generators instantiate it, and it reports bound hits and overflow/underflow events to control logic.

## Interface
- WIDTH, 32: counter and bound width in bits.
- STEP_WIDTH, 8: width of the step input. Must satisfy STEP_WIDTH ≤ WIDTH.
- MODE, MODE_WRAP: MODE_WRAP jumps to the opposite bound on crossing; MODE_SAT clamps at the crossed bound.
- RESET_VALUE, 0: count value after reset.

Ports:
- clk  in  1  sole clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; one step per cycle while high.
- down  in  1  0 = count up, 1 = count down; sampled with en.
- step  in  STEP_WIDTH  unsigned increment per enabled cycle.
- load  in  1  synchronous load of load_value.
- load_value  in  WIDTH  value written on load.
- lim_lo  in  WIDTH  lower bound, inclusive.
- lim_hi  in  WIDTH  upper bound, inclusive. lim_lo ≤ lim_hi is required; behaviour is unchecked otherwise.
- count  out  WIDTH  registered counter value.
- at_lo  out  1  combinational: count == lim_lo.
- at_hi  out  1  combinational: count == lim_hi.
- ovf  out  1  registered one-cycle pulse: an up step crossed lim_hi.
- unf  out  1  registered one-cycle pulse: a down step crossed lim_lo.

## Operation
- Priority each cycle: rst > load > en > hold.
- rst: count = RESET_VALUE; ovf = unf = 0.
- load: count = load_value, even if it lies outside [lim_lo, lim_hi]; ovf = unf = 0.
- en & !down: compute sum = count + step in WIDTH+1 bits, so the carry is kept.
  - If sum ≤ lim_hi: count = sum.
  - Else: count = lim_lo in WRAP mode, lim_hi in SAT mode; ovf = 1.
- en & down: compute diff = count − step in WIDTH+1 bits, signed, so the borrow is kept.
  - If diff ≥ lim_lo: count = diff.
  - Else: count = lim_hi in WRAP mode, lim_lo in SAT mode; unf = 1.
- Wrap does not carry the remainder. The count lands exactly on the opposite bound.
- step = 0 with en: count holds, no flags. at_lo/at_hi still reflect count.
- SAT mode at bound: an up step at count == lim_hi re-pulses ovf every enabled cycle; a down step at lim_lo re-pulses unf likewise.
- Count above lim_hi (after load or a bound change) with an up step: ovf; the count goes to lim_lo (WRAP) or lim_hi (SAT).
- Count below lim_lo with a down step: unf; the count goes to lim_hi (WRAP) or lim_lo (SAT).
- Count outside the range with a step toward the range: ordinary arithmetic, no flag.
- lim_lo/lim_hi may change at any cycle. The new values apply to the step computed in that same cycle.
- ovf and unf are never high together.

## Timing
- Latency 1 cycle: inputs sampled at edge N; count/ovf/unf valid after edge N.
- ovf/unf are high for exactly the cycle following the crossing step, aligned with the wrapped or saturated count.
- at_lo/at_hi are combinational from count and the limits. There is no extra latency, and they change the same cycle the limits change.
- rst asserted mid-count: count = RESET_VALUE on the next edge regardless of en/load. Pending flags are cleared.
- Full-range operation (lim_lo = 0, lim_hi = 2^WIDTH−1) in WRAP mode equals modulo-2^WIDTH counting only for step = 1. Larger steps land on the bound rather than continuing modulo.

## Structure
- Package counter_pkg holds MODE_WRAP = 0 and MODE_SAT = 1 as localparams or an enum. Future counter variants share it.
- Sub-module updown_next (combinational) takes count, step, down, lim_lo, lim_hi and MODE. It returns next_count, ovf_next and unf_next.
- The top-level contains only the priority mux, the registers and the at_lo/at_hi compares.

## Test plan
- Reset value: RESET_VALUE = 5, WIDTH = 8, rst held 2 cycles with en = 1 → count = 5, ovf = unf = 0.
- Wrap up: lim = [10, 20], WRAP, load 18, step = 2, up → count 20 (at_hi = 1), then 10 with ovf pulse of 1 cycle, then 12.
- Saturate down: SAT, lim = [10, 20], load 13, step = 4, down → 10 with unf = 1, then 10 with unf = 1 again; at_lo = 1 throughout.
- Carry edge: WIDTH = 8, lim = [0, 255], WRAP, load 250, step = 10, up → sum 260 is detected via the carry bit; count = 0, ovf = 1.
- Priority and out-of-range: count = 15, assert load = 1 with load_value = 30 and en = 1 in the same cycle → count = 30 (load wins, no flag). Next cycle up, step = 1, lim_hi = 20, WRAP → count = 10, ovf = 1.
- Mid-run reset and step = 0: counting at 17, rst for 1 cycle → count = RESET_VALUE. Then en with step = 0 for 3 cycles → count unchanged, no flags.
